// File: rtl/pe_dot_result_collector.sv
// Collects dot-unit results into reduction sums and queues them in a small output FIFO.
// Issue-side credits (FIFO occupancy plus in-flight reduction ends) drive o_stall.
module pe_dot_result_collector #(
    parameter int unsigned DOT_OUTPUT_WIDTH = 24,
    parameter int unsigned ACCUM_WIDTH      = 32,
    parameter int unsigned DOT_LATENCY      = 3,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               i_issue_valid,
    input  logic                               i_issue_last,
    input  logic signed [DOT_OUTPUT_WIDTH-1:0] i_dot_result,
    output logic                               o_stall,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic signed [ACCUM_WIDTH-1:0]      o_data,
    output logic [$clog2(FIFO_DEPTH):0]        o_count,
    output logic                               o_error
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {StIdle = 1'b0, StAccum = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [DOT_LATENCY-1:0]        av_line_q, al_line_q;
    logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACCUM_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]               count_q;
    logic                          error_q;

    logic                          av, al;
    logic signed [ACCUM_WIDTH-1:0] ext_result, sum;
    logic                          add_ovf, ovf;
    logic                          push, do_push, drop, pop, full;
    logic signed [ACCUM_WIDTH-1:0] push_data;
    int unsigned                   credit;

    assign av         = av_line_q[DOT_LATENCY-1];
    assign al         = av & al_line_q[DOT_LATENCY-1];
    assign ext_result = ACCUM_WIDTH'(i_dot_result);
    assign sum        = acc_q + ext_result;
    assign add_ovf    = (acc_q[ACCUM_WIDTH-1] == ext_result[ACCUM_WIDTH-1]) &&
                        (sum[ACCUM_WIDTH-1] != acc_q[ACCUM_WIDTH-1]);

    // Issue strobes travel alongside the dot unit so they line up with i_dot_result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            av_line_q <= '0;
            al_line_q <= '0;
        end else begin
            av_line_q[0] <= i_issue_valid;
            al_line_q[0] <= i_issue_valid & i_issue_last;
            for (int i = 1; i < int'(DOT_LATENCY); i++) begin
                av_line_q[i] <= av_line_q[i-1];
                al_line_q[i] <= al_line_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Both states make the same move on an aligned term: a last term closes the reduction.
    always_comb begin
        state_d = state_q;
        if (av) begin
            state_d = al ? StIdle : StAccum;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        push      = 1'b0;
        push_data = ext_result;
        ovf       = 1'b0;
        if (av) begin
            unique case (state_q)
                StIdle: begin
                    if (al) push = 1'b1;
                    else    acc_d = ext_result;
                end
                StAccum: begin
                    ovf = add_ovf;
                    if (al) begin
                        push      = 1'b1;
                        push_data = sum;
                    end else begin
                        acc_d = sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign o_valid = (count_q != '0);
    assign pop     = o_valid & i_ready;
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - CntW'(1);
            end
            error_q <= error_q | ovf | drop;
        end
    end

    // Every in-flight last term is guaranteed a slot, so stall on committed occupancy.
    always_comb begin
        credit = 32'(count_q);
        for (int i = 0; i < int'(DOT_LATENCY); i++) begin
            credit += 32'(al_line_q[i]);
        end
    end

    assign o_stall = (credit >= FIFO_DEPTH);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_error = error_q;

endmodule

// File: doc/pe_dot_result_collector.md
PE_DOT_RESULT_COLLECTOR -- requirements
Module: pe_dot_result_collector

Interface
REQ-001 SHALL have parameter DOT_OUTPUT_WIDTH, default 24: signed width of the incoming dot result.
REQ-002 SHALL have parameter ACCUM_WIDTH, default 32, at least DOT_OUTPUT_WIDTH: signed accumulator and output width.
REQ-003 SHALL have parameter DOT_LATENCY, default 3, at least 1: cycles from dot issue to a valid i_dot_result.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2: number of output result entries.
REQ-005 SHALL have ports clock, input, 1: single clock, rising edge.
REQ-006 SHALL have ports resetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports i_issue_valid, input, 1: the feeder presented feature/filter operands to the dot unit this cycle.
REQ-008 SHALL have ports i_issue_last, input, 1: the issued dot is the final term of a reduction; qualified by i_issue_valid.
REQ-009 SHALL have ports i_dot_result, input, DOT_OUTPUT_WIDTH, signed: dot unit output, valid DOT_LATENCY cycles after issue.
REQ-010 SHALL have ports o_stall, output, 1: the feeder shall not issue with i_issue_last=1 while this is high.
REQ-011 SHALL have ports o_valid, output, 1: head entry of the output FIFO is valid.
REQ-012 SHALL have ports i_ready, input, 1: downstream accepts the head entry.
REQ-013 SHALL have ports o_data, output, ACCUM_WIDTH, signed: head reduction sum.
REQ-014 SHALL have ports o_count, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-015 SHALL have ports o_error, output, 1: sticky flag for accumulator overflow or a dropped push.

Function
REQ-016 SHALL delay i_issue_valid and i_issue_last by exactly DOT_LATENCY cycles to form aligned signals av and al, where al is qualified by av.
REQ-017 SHALL sign-extend i_dot_result to ACCUM_WIDTH before it is added.
REQ-018 SHALL run a 2-state FSM: IDLE (no partial sum) and ACCUM (partial sum held).
- IDLE, av and not al: acc becomes ext(result); next state ACCUM.
- IDLE, av and al: push ext(result) directly; stay IDLE.
- ACCUM, av and not al: acc becomes acc + ext(result); stay ACCUM.
- ACCUM, av and al: push acc + ext(result); next state IDLE.
- No av: hold acc and state.
REQ-019 SHALL use two's-complement wrap for addition and SHALL set o_error when a signed overflow occurs in an add.
REQ-020 SHALL write a pushed sum into the FIFO on the clock edge that ends the cycle in which al is high.
REQ-021 SHALL raise o_valid on the following cycle, so that total latency from i_issue_valid with i_issue_last to o_valid is DOT_LATENCY+1 cycles when the FIFO is empty.
REQ-022 SHALL pop the FIFO when o_valid and i_ready are both high; i_ready SHALL be ignored when the FIFO is empty.
REQ-023 SHALL, when a push and a pop occur in the same cycle, perform both with o_count unchanged, including when the FIFO is full.
REQ-024 SHALL, when a push occurs while the FIFO is full with no pop, drop the push, set o_error, and leave the FIFO contents unchanged.
REQ-025 SHALL keep o_data stable while o_valid is high and i_ready is low.
REQ-026 SHALL keep a credit count C equal to o_count plus the number of in-flight aligned-last bits in the delay line.
REQ-027 SHALL assert o_stall combinationally when C >= FIFO_DEPTH, so that a compliant feeder never causes a drop.
REQ-028 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with full and empty distinguished by o_count.

Reset
REQ-029 SHALL, while resetn is low, asynchronously clear the delay line, acc (to 0), FSM (to IDLE), both FIFO pointers, o_count (to 0), o_valid (to 0), o_stall (to 0), and o_error (to 0).
REQ-030 SHALL hold o_data at 0 after reset until the first push.
REQ-031 SHALL discard any partial sum and any in-flight results on a mid-operation reset, with nothing pushed as a result.
REQ-032 SHALL apply the reset release synchronously to clock.

Verification
REQ-033 SHALL verify single-term reduction: issue with last=1 at cycle 0 and result=-5 at cycle 3 -> o_valid=1 at cycle 4, o_data=-5, o_count=1.
REQ-034 SHALL verify a 3-term reduction: results 10, -3, 7 with last on the third term -> exactly one entry with o_data=14, FSM returns to IDLE.
REQ-035 SHALL verify backpressure: i_ready=0 with 4 single-term reductions issued back-to-back -> o_stall=1 from the cycle after the 4th issue, o_count reaches 4, o_error=0; a single pop clears o_stall on the following cycle.
REQ-036 SHALL verify simultaneous push and pop when full: o_count stays 4, data order is preserved first-in first-out, and o_error stays 0.
REQ-037 SHALL verify overflow and drop:
- ACCUM_WIDTH=24, two terms of 0x7FFFFF -> o_error=1 and sum 0xFFFFFE.
- A forced push into a full FIFO -> o_error=1 and o_count stays 4.
REQ-038 SHALL verify mid-reduction reset: reset asserted after 2 of 3 terms -> all outputs are 0, and a following 1-term reduction of 9 -> o_data=9.
